// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-lane data memory interface.
// Takes one load/store at a time from execute, screens it for opcode,
// alignment and range faults, drives a single-cycle memory access and
// returns the captured result over a valid/ready response channel.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request
// ISSUE   | memory address/masks driven for exactly one cycle
// CAPTURE | memory read data and error flags registered into response
// FAULT   | request rejected before memory, error response registered
// RESP    | response valid, held until the consumer takes it
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [1:0]  o_resp_err,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wr_data,
    output logic [1:0]  o_mem_wr_mask,
    output logic [2:0]  o_mem_rd_mask,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_err_misaligned,
    input  logic        i_mem_err_invalid_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_FAULT,
        S_RESP
    } state_t;

    localparam logic [1:0] WR_N = 2'd0, WR_B = 2'd1, WR_H = 2'd2, WR_W = 2'd3;
    localparam logic [2:0] RD_W  = 3'd0, RD_HZ = 3'd1, RD_BZ = 3'd2,
                           RD_HE = 3'd3, RD_BE = 3'd4, RD_XX = 3'd5;
    localparam logic [1:0] ERR_OK = 2'd0, ERR_MIS = 2'd1, ERR_RANGE = 2'd2, ERR_INV = 2'd3;

    state_t      state, state_nx;
    logic        accept;
    logic        op_bad, misaligned;
    logic [1:0]  cls_err;
    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_flt;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    assign o_req_ready  = (state == S_IDLE) || ((state == S_RESP) && i_resp_ready);
    assign accept       = i_req_valid && o_req_ready;
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_data  = resp_data;
    assign o_resp_err   = resp_err;

    // Classify the incoming request: invalid op beats misalignment beats range.
    always_comb begin
        op_bad     = 1'b0;
        misaligned = 1'b0;
        cls_err    = ERR_OK;
        if (i_req_we) begin
            op_bad = i_req_op[2] || (i_req_op[1:0] == 2'b11);
        end else begin
            op_bad = (i_req_op[1:0] == 2'b11) || (i_req_op[2:1] == 2'b11);
        end
        misaligned = ((i_req_op[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_op[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        if (op_bad) begin
            cls_err = ERR_INV;
        end else if (misaligned) begin
            cls_err = ERR_MIS;
        end else if (i_req_addr >= 32'(MEM_BYTES)) begin
            cls_err = ERR_RANGE;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and memory port drive; the memory only sees a request in ISSUE.
    always_comb begin
        state_nx      = state;
        o_mem_address = 32'd0;
        o_mem_wr_data = 32'd0;
        o_mem_wr_mask = WR_N;
        o_mem_rd_mask = RD_XX;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (cls_err != ERR_OK) ? S_FAULT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_address = r_addr;
                o_mem_wr_data = r_wdata;
                if (r_we) begin
                    case (r_op[1:0])
                        2'b00:   o_mem_wr_mask = WR_B;
                        2'b01:   o_mem_wr_mask = WR_H;
                        2'b10:   o_mem_wr_mask = WR_W;
                        default: o_mem_wr_mask = WR_N;
                    endcase
                end else begin
                    case (r_op)
                        3'b000:  o_mem_rd_mask = RD_BE;
                        3'b001:  o_mem_rd_mask = RD_HE;
                        3'b010:  o_mem_rd_mask = RD_W;
                        3'b100:  o_mem_rd_mask = RD_BZ;
                        3'b101:  o_mem_rd_mask = RD_HZ;
                        default: o_mem_rd_mask = RD_XX;
                    endcase
                end
                state_nx = S_CAPTURE;
            end
            S_CAPTURE: state_nx = S_RESP;
            S_FAULT:   state_nx = S_RESP;
            S_RESP: begin
                if (i_resp_ready) begin
                    if (accept) begin
                        state_nx = (cls_err != ERR_OK) ? S_FAULT : S_ISSUE;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latch the request fields and their classification at acceptance.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_we    <= 1'b0;
            r_op    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_flt   <= ERR_OK;
        end else if (accept) begin
            r_we    <= i_req_we;
            r_op    <= i_req_op;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_flt   <= cls_err;
        end
    end

    // Build the response; it is only written on the way into RESP, so it holds while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            resp_data <= 32'd0;
            resp_err  <= ERR_OK;
        end else if (state == S_CAPTURE) begin
            if (i_mem_err_misaligned) begin
                resp_data <= 32'd0;
                resp_err  <= ERR_MIS;
            end else if (i_mem_err_invalid_rd) begin
                resp_data <= 32'd0;
                resp_err  <= ERR_INV;
            end else begin
                resp_data <= r_we ? 32'd0 : i_mem_rd_data;
                resp_err  <= ERR_OK;
            end
        end else if (state == S_FAULT) begin
            resp_data <= 32'd0;
            resp_err  <= r_flt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks of load_store_unit
// against a transaction-level model and a byte-array memory environment.
module tb_load_store_unit;
    localparam int MEM_BYTES = 4096;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_op = 3'd0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [31:0] o_resp_data;
    logic [1:0]  o_resp_err;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_wr_data;
    logic [1:0]  o_mem_wr_mask;
    logic [2:0]  o_mem_rd_mask;
    logic [31:0] i_mem_rd_data = 32'd0;
    logic        i_mem_err_misaligned = 1'b0;
    logic        i_mem_err_invalid_rd = 1'b0;

    always #5 i_clk = ~i_clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_we            (i_req_we),
        .i_req_op            (i_req_op),
        .i_req_addr          (i_req_addr),
        .i_req_wdata         (i_req_wdata),
        .o_resp_valid        (o_resp_valid),
        .i_resp_ready        (i_resp_ready),
        .o_resp_data         (o_resp_data),
        .o_resp_err          (o_resp_err),
        .o_mem_address       (o_mem_address),
        .o_mem_wr_data       (o_mem_wr_data),
        .o_mem_wr_mask       (o_mem_wr_mask),
        .o_mem_rd_mask       (o_mem_rd_mask),
        .i_mem_rd_data       (i_mem_rd_data),
        .i_mem_err_misaligned(i_mem_err_misaligned),
        .i_mem_err_invalid_rd(i_mem_err_invalid_rd)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory environment (registered read, byte lanes) -------------
    logic [7:0] env_mem [0:MEM_BYTES-1] = '{default: 8'h00};
    logic       inj_mis = 1'b0;
    logic       inj_inv = 1'b0;

    function automatic logic [31:0] env_read(input logic [11:0] a, input logic [2:0] m);
        logic [31:0] w;
        w = {env_mem[a + 12'd3], env_mem[a + 12'd2], env_mem[a + 12'd1], env_mem[a]};
        case (m)
            3'd0:    return w;
            3'd1:    return {16'h0, w[15:0]};
            3'd2:    return {24'h0, w[7:0]};
            3'd3:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {{24{w[7]}}, w[7:0]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge i_clk) begin
        case (o_mem_wr_mask)
            2'd1: env_mem[o_mem_address[11:0]] <= o_mem_wr_data[7:0];
            2'd2: begin
                env_mem[o_mem_address[11:0]]         <= o_mem_wr_data[7:0];
                env_mem[o_mem_address[11:0] + 12'd1] <= o_mem_wr_data[15:8];
            end
            2'd3: begin
                env_mem[o_mem_address[11:0]]         <= o_mem_wr_data[7:0];
                env_mem[o_mem_address[11:0] + 12'd1] <= o_mem_wr_data[15:8];
                env_mem[o_mem_address[11:0] + 12'd2] <= o_mem_wr_data[23:16];
                env_mem[o_mem_address[11:0] + 12'd3] <= o_mem_wr_data[31:24];
            end
            default: ;
        endcase
        if (o_mem_rd_mask != 3'd5) begin
            i_mem_rd_data        <= env_read(o_mem_address[11:0], o_mem_rd_mask);
            i_mem_err_misaligned <= inj_mis;
            i_mem_err_invalid_rd <= inj_inv;
        end else begin
            i_mem_rd_data        <= $urandom;
            i_mem_err_misaligned <= 1'b0;
            i_mem_err_invalid_rd <= 1'b0;
        end
    end

    // ---------------- transaction-level reference model ---------------------------
    logic [7:0]  ref_mem [0:MEM_BYTES-1] = '{default: 8'h00};
    bit          m_live = 1'b0;
    bit          enable_inj = 1'b0;
    int          m_cnt = 0;          // cycles until the pending response becomes visible
    bit          m_rv = 1'b0;
    logic [31:0] m_rdata = 32'd0, m_pdata = 32'd0;
    logic [1:0]  m_rerr = 2'd0, m_perr = 2'd0;
    bit          m_acc = 1'b0;       // a memory access is expected this cycle
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
    logic [1:0]  m_wm = 2'd0;
    logic [2:0]  m_rm = 3'd5;
    bit          exp_ready;

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
        int nb;
        logic [31:0] v;
        nb = 1 << op[1:0];
        v = 32'd0;
        for (int k = 0; k < nb; k++) begin
            v = v | (32'(ref_mem[(int'(addr) + k) % MEM_BYTES]) << (8 * k));
        end
        if (!op[2] && nb < 4 && v[8 * nb - 1]) begin
            v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        end
        return v;
    endfunction

    initial begin
        forever begin
            @(negedge i_clk);
            exp_ready = (m_cnt == 0) && (!m_rv || i_resp_ready);
            if (m_live) begin
                chk("req_ready", 32'(o_req_ready), 32'(exp_ready));
                chk("resp_valid", 32'(o_resp_valid), 32'(m_rv));
                if (m_rv) begin
                    chk("resp_data", o_resp_data, m_rdata);
                    chk("resp_err", 32'(o_resp_err), 32'(m_rerr));
                end
                chk("mem_address", o_mem_address, m_acc ? m_addr : 32'd0);
                chk("mem_wr_data", o_mem_wr_data, m_acc ? m_wdata : 32'd0);
                chk("mem_wr_mask", 32'(o_mem_wr_mask), m_acc ? 32'(m_wm) : 32'd0);
                chk("mem_rd_mask", 32'(o_mem_rd_mask), m_acc ? 32'(m_rm) : 32'd5);
            end
            if (!i_reset) begin
                m_live = 1'b1;
                m_cnt  = 0;
                m_rv   = 1'b0;
                m_acc  = 1'b0;
            end else if (m_live) begin
                bit       bad, mis, oor, acc;
                int       sz;
                logic [1:0] err;
                acc = i_req_valid && exp_ready;
                if (m_rv && i_resp_ready) m_rv = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_rv    = 1'b1;
                        m_rdata = m_pdata;
                        m_rerr  = m_perr;
                    end
                end
                m_acc = 1'b0;
                if (acc) begin
                    sz  = int'(i_req_op[1:0]);
                    bad = i_req_we ? (i_req_op > 3'd2) : (i_req_op == 3'd3 || i_req_op >= 3'd6);
                    mis = (sz == 1 && i_req_addr[0]) || (sz == 2 && i_req_addr[1:0] != 2'b00);
                    oor = i_req_addr >= 32'(MEM_BYTES);
                    err = bad ? 2'd3 : mis ? 2'd1 : oor ? 2'd2 : 2'd0;
                    if (err != 2'd0) begin
                        m_cnt  = 1;
                        m_pdata = 32'd0;
                        m_perr  = err;
                    end else begin
                        m_cnt   = 2;
                        m_acc   = 1'b1;
                        m_addr  = i_req_addr;
                        m_wdata = i_req_wdata;
                        if (i_req_we) begin
                            m_wm = 2'(sz + 1);
                            m_rm = 3'd5;
                            for (int k = 0; k < (1 << sz); k++) begin
                                ref_mem[(int'(i_req_addr) + k) % MEM_BYTES] = i_req_wdata[8*k +: 8];
                            end
                            inj_mis = 1'b0;
                            inj_inv = 1'b0;
                            m_pdata = 32'd0;
                            m_perr  = 2'd0;
                        end else begin
                            m_wm = 2'd0;
                            case (i_req_op)
                                3'd0:    m_rm = 3'd4;
                                3'd1:    m_rm = 3'd3;
                                3'd2:    m_rm = 3'd0;
                                3'd4:    m_rm = 3'd2;
                                default: m_rm = 3'd1;
                            endcase
                            inj_mis = enable_inj && ($urandom % 10 == 0);
                            inj_inv = enable_inj && ($urandom % 10 == 0);
                            m_perr  = inj_mis ? 2'd1 : inj_inv ? 2'd3 : 2'd0;
                            m_pdata = (m_perr != 2'd0) ? 32'd0 : ref_load(i_req_addr, i_req_op);
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed driver ---------------------------------------------
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_req_ready || n > 20) break;
            n++;
        end
        chk(name, 32'(o_req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] d, output logic [1:0] e,
                          output int lat, output int wr);
        i_resp_ready = 1'b1;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_op     = op;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        wait_accept("accept");
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_wdata = $urandom;
        lat = 0;
        wr  = 0;
        forever begin
            @(negedge i_clk);
            lat++;
            if (o_mem_wr_mask != 2'd0) wr++;
            if (o_resp_valid || lat > 10) break;
        end
        chk("resp_seen", 32'(o_resp_valid), 32'd1);
        d = o_resp_data;
        e = o_resp_err;
        @(posedge i_clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic [1:0]  exp_e;
        int          exp_lat;
        int          exp_wr;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        int          lat, wr, n;

        vecs.push_back('{1'b1, 3'd2, 32'h10,   32'h8899AABB, 32'h0,        2'd0, 3, 1, "sw_10"});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'h8899AABB, 2'd0, 3, 0, "lw_10"});
        vecs.push_back('{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFF88, 2'd0, 3, 0, "lb_13"});
        vecs.push_back('{1'b0, 3'd4, 32'h13,   32'h0,        32'h00000088, 2'd0, 3, 0, "lbu_13"});
        vecs.push_back('{1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFF8899, 2'd0, 3, 0, "lh_12"});
        vecs.push_back('{1'b0, 3'd5, 32'h12,   32'h0,        32'h00008899, 2'd0, 3, 0, "lhu_12"});
        vecs.push_back('{1'b1, 3'd1, 32'h11,   32'h1234,     32'h0,        2'd1, 2, 0, "sh_11"});
        vecs.push_back('{1'b0, 3'd2, 32'h22,   32'h0,        32'h0,        2'd1, 2, 0, "lw_22"});
        vecs.push_back('{1'b1, 3'd2, 32'h1000, 32'h55,       32'h0,        2'd2, 2, 0, "sw_1000"});
        vecs.push_back('{1'b1, 3'd4, 32'h14,   32'h77,       32'h0,        2'd3, 2, 0, "st_op4"});
        vecs.push_back('{1'b0, 3'd6, 32'h11,   32'h0,        32'h0,        2'd3, 2, 0, "ld_op6"});
        vecs.push_back('{1'b0, 3'd2, 32'hFFC,  32'h0,        32'h0,        2'd0, 3, 0, "lw_ffc"});

        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(negedge i_clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        chk("rst_wr_mask", 32'(o_mem_wr_mask), 32'd0);
        chk("rst_rd_mask", 32'(o_mem_rd_mask), 32'd5);
        chk("rst_resp_data", o_resp_data, 32'd0);
        chk("rst_resp_err", 32'(o_resp_err), 32'd0);
        @(posedge i_clk); #1;

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, d, e, lat, wr);
            chk({vecs[i].name, "_data"}, d, vecs[i].exp_d);
            chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_e));
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_wr_cycles"}, 32'(wr), 32'(vecs[i].exp_wr));
        end

        // Stall the response five cycles, then release it together with a queued SB.
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_op     = 3'd2;
        i_req_addr   = 32'h10;
        wait_accept("hold_accept");
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_resp_valid || n > 10) break;
            n++;
        end
        chk("hold_first_valid", 32'(o_resp_valid), 32'd1);
        repeat (5) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_resp_valid), 32'd1);
            chk("hold_data", o_resp_data, 32'h8899AABB);
            chk("hold_err", 32'(o_resp_err), 32'd0);
            chk("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        @(posedge i_clk); #1;
        i_resp_ready = 1'b1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_op     = 3'd0;
        i_req_addr   = 32'h20;
        i_req_wdata  = 32'h5A;
        @(negedge i_clk);
        chk("sb_same_cycle_ready", 32'(o_req_ready), 32'd1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("sb_issue_wr_mask", 32'(o_mem_wr_mask), 32'd1);
        chk("sb_issue_addr", o_mem_address, 32'h20);
        chk("sb_issue_wdata", o_mem_wr_data, 32'h5A);
        repeat (3) @(posedge i_clk);
        #1;

        // Reset while an LW sits in CAPTURE: the response must vanish.
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_op    = 3'd2;
        i_req_addr  = 32'h10;
        wait_accept("rstcap_accept");
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            chk("rstcap_no_resp", 32'(o_resp_valid), 32'd0);
            chk("rstcap_ready", 32'(o_req_ready), 32'd1);
        end
        @(posedge i_clk); #1;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, d, e, lat, wr);
        chk("post_rst_lw_data", d, 32'h8899AABB);
        chk("post_rst_lw_lat", 32'(lat), 32'd3);

        // Randomized traffic with backpressure, memory error injection and resets.
        enable_inj = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            @(posedge i_clk); #1;
            i_reset     = ($urandom % 300) != 0;
            i_req_valid = ($urandom % 10) < 6;
            i_req_we    = 1'($urandom);
            i_req_op    = 3'($urandom);
            r = int'($urandom % 16);
            if (r == 0)      i_req_addr = $urandom;
            else if (r == 1) i_req_addr = 32'd4092 + ($urandom % 8);
            else             i_req_addr = $urandom % 64;
            i_req_wdata  = $urandom;
            i_resp_ready = ($urandom % 10) < 7;
        end
        @(posedge i_clk); #1;
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
